// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box table, GF(2^8) doubling, FSM state type and
// the round/rcon constants used by the iterative round controller.
package aes_pkg;

    localparam int         NR_AES128 = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    // Element 0 sits in the most significant byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/AddRoundKey.sv
// AddRoundKey: XOR of the state with the current round key.
module AddRoundKey (
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic [127:0] result
);

    assign result = data ^ key;

endmodule

// File: rtl/MixColumns.sv
// MixColumns: each column multiplied by the fixed {02,03,01,01} circulant in GF(2^8).
module MixColumns
    import aes_pkg::*;
(
    input  logic [127:0] data,
    output logic [127:0] result
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data[127-32*c -: 8];
        assign a1 = data[119-32*c -: 8];
        assign a2 = data[111-32*c -: 8];
        assign a3 = data[103-32*c -: 8];

        assign result[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign result[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign result[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign result[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/Shift_Rows.sv
// ShiftRows: row r of the column-major state rotates left by r byte positions.
module Shift_Rows (
    input  logic [127:0] data,
    output logic [127:0] result
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign result[127-8*(4*c+r) -: 8] = data[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end

endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives round key K_r from K_(r-1) and rcon.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;

    // SubWord(RotWord(w3)) with the round constant folded into the top byte.
    assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                  ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/subBytes.sv
// SubBytes: byte-wise S-box substitution of the 128-bit state.
module subBytes
    import aes_pkg::*;
(
    input  logic [127:0] data,
    output logic [127:0] result
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign result[127-8*i -: 8] = sbox(data[127-8*i -: 8]);
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock through a shared datapath,
// round keys expanded on the fly, valid/ready handshakes on both sides.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output aes_state_e   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; in_ready is high only in IDLE, out_valid only in DONE, neither waits on the other.

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    aes_state_e   state, state_next;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [7:0]   rcon;
    logic [3:0]   round_cnt;

    logic         last_round;
    logic [127:0] sb_out, sr_out, mc_out, mix_sel, round_key, round_out;

    assign last_round = (round_cnt == LAST_ROUND);

    subBytes     u_sub_bytes  (.data(state_reg), .result(sb_out));
    Shift_Rows   u_shift_rows (.data(sb_out),    .result(sr_out));
    MixColumns   u_mix_cols   (.data(sr_out),    .result(mc_out));

    // The final round skips MixColumns.
    assign mix_sel = last_round ? sr_out : mc_out;

    aes_key_step u_key_step (.key(key_reg), .rcon(rcon), .next_key(round_key));
    AddRoundKey  u_add_key  (.data(mix_sel), .key(round_key), .result(round_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = ST_ROUND;
            end
            ST_ROUND: begin
                if (last_round) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            key_reg   <= '0;
            rcon      <= RCON_INIT;
            round_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data ^ in_key;
                        key_reg   <= in_key;
                        rcon      <= RCON_INIT;
                        round_cnt <= 4'd1;
                    end
                end
                ST_ROUND: begin
                    state_reg <= round_out;
                    key_reg   <= round_key;
                    rcon      <= xtime(rcon);
                    // Parking the counter at 0 keeps the value 11 unreachable.
                    round_cnt <= last_round ? 4'd0 : round_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_data  = state_reg;
    assign dbg_state = state;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; only 10 (AES-128) SHALL be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  plaintext/key presented.
REQ-005 in_ready  output  1  block can accept a new job.
REQ-006 in_data  input  128  plaintext, FIPS-197 byte order (in_data[127:120] = byte 0, column-major).
REQ-007 in_key  input  128  cipher key, same byte order.
REQ-008 out_valid  output  1  ciphertext available.
REQ-009 out_ready  input  1  consumer takes ciphertext.
REQ-010 out_data  output  128  ciphertext, same byte order.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL compute AES-128 encryption iteratively: one round per clock, using one shared round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and on-the-fly key expansion.
REQ-013 FSM states SHALL be IDLE, ROUND, DONE; no other reachable states.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, state_reg <= in_data ^ in_key, key_reg <= in_key, round counter <= 1, rcon <= 8'h01, go to ROUND.
REQ-015 ROUND: each edge applies round r with round key K_r derived from key_reg and rcon; key_reg <= K_r; rcon <= xtime(rcon) (0x80 -> 0x1B); counter +1.
REQ-016 Rounds 1..9 SHALL include MixColumns; round 10 SHALL bypass MixColumns.
REQ-017 After the round-10 edge, the FSM SHALL enter DONE with out_valid=1.
REQ-018 Latency: out_valid SHALL first be high exactly 10 rising edges after the accepting edge.
REQ-019 DONE: out_data and out_valid SHALL hold stable until out_ready=1; on out_valid&out_ready, go to IDLE (out_valid low next cycle).
REQ-020 in_ready SHALL be 1 only in IDLE; in_valid in ROUND/DONE SHALL be ignored, and in_data/in_key changes after acceptance SHALL NOT affect the result.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 Throughput: at most one job per 12 cycles (accept, 10 rounds, handoff); in DONE, in_ready SHALL stay 0 in the handoff cycle even when out_ready=1.
REQ-023 Counter SHALL be 4 bits; it SHALL not advance outside ROUND; the value 11 SHALL be unreachable.
REQ-024 out_data SHALL equal state_reg (registered output, no combinational path from inputs).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready=1 once released, out_valid=0, busy=0, out_data=0, counter=0, rcon=8'h01, key_reg=0.
REQ-026 Reset mid-ROUND or mid-DONE SHALL discard the job with no out_valid pulse afterwards.
REQ-027 Reset deassertion is synchronous to clk upstream; the block SHALL accept a job on the first edge after release.

Structure
REQ-028 A shared package aes_pkg SHALL hold the S-box table, the xtime function, the FSM state typedef, and constants NR_AES128=10 and RCON_INIT=8'h01.
REQ-029 Key expansion step SHALL be a sub-module aes_key_step (inputs: 128-bit key, 8-bit rcon; output: next 128-bit round key), purely combinational.
REQ-030 The round datapath SHALL reuse the existing subBytes, Shift_Rows, MixColumns and AddRoundKey modules, with a mux selecting the MixColumns bypass in round 10.

Verification
REQ-031 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid 10 edges after accept.
REQ-032 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0 throughout, single handoff when out_ready=1.
REQ-034 Busy ignore: in_valid held high with changing in_data during ROUND -> first job result unchanged; second job accepted only in IDLE, 12 cycles after the first.
REQ-035 Reset at round 5 -> out_valid stays 0; the next job (App. B vector) completes correctly with 10-edge latency.
REQ-036 Random: 1000 random key/pt pairs with random out_ready stalls -> every result matches the reference model, no lost or duplicated outputs.
